io_key_sw: RTL and testbench

IO_KEY_SW -- requirements
Module: io_key_sw

---
 rtl/io_pkg.sv | 26 ++
 rtl/io_key_sw_if.sv | 17 +
 rtl/io_debounce.sv | 55 +++++
 rtl/io_key_sw.sv | 162 ++++++++++++++++
 tb/tb_io_key_sw.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared constants for the key/switch I/O device.
//   Default bus addresses of the four device registers, CTRL bit positions,
//   and a helper that packs a CTRL word from its three state bits.
`timescale 1ns/1ps
package io_pkg;

    localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
    localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;
    localparam logic [31:0] SDATA_ADDR = 32'hF000_0014;
    localparam logic [31:0] SCTRL_ADDR = 32'hF000_0114;

    localparam int CTRL_READY = 0;
    localparam int CTRL_OVR   = 2;
    localparam int CTRL_IE    = 4;

    // Unused CTRL bits read as zero.
    function automatic logic [31:0] ctrl_word(input logic rdy, input logic ovr, input logic ie);
        logic [31:0] w;
        w             = '0;
        w[CTRL_READY] = rdy;
        w[CTRL_OVR]   = ovr;
        w[CTRL_IE]    = ie;
        return w;
    endfunction

endpackage

// File: rtl/io_key_sw_if.sv
// io_key_sw_if: simple register bus between a CPU-side master and the device.
//   addr/wr_en/rd_en/wr_data driven by the master; rd_data/rd_hit returned
//   combinationally by the slave. Strobes are one cycle per access.
`timescale 1ns/1ps
interface io_key_sw_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             wr_en;
    logic             rd_en;
    logic [DBITS-1:0] wr_data;
    logic [DBITS-1:0] rd_data;
    logic             rd_hit;

    modport master (output addr, wr_en, rd_en, wr_data, input  rd_data, rd_hit);
    modport slave  (input  addr, wr_en, rd_en, wr_data, output rd_data, rd_hit);
endinterface

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchronizer followed by a stability filter.
//   clk, reset : clock, async active-high reset
//   d_in       : raw asynchronous input vector
//   cand       : last synchronized value seen (debounce candidate)
//   stable     : cand has now been constant for WINDOW consecutive samples
//                (asserted in the cycle the counter reaches / sits at WINDOW-1)
`timescale 1ns/1ps
module io_debounce #(
    parameter int WIDTH  = 10,
    parameter int WINDOW = 4      // must be >= 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] cand,
    output logic             stable
);
    localparam int                CNT_W   = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WINDOW - 1);

    logic [WIDTH-1:0] meta_q, sync_q;
    logic [WIDTH-1:0] cand_d, cand_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Looking at cnt_d lets the consumer act in the same edge the window
    // completes; a change this cycle forces cnt_d to 0, so stable implies
    // cand_d == cand_q.
    assign stable = (cnt_d == CNT_MAX);
    assign cand   = cand_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/io_key_sw.sv
// io_key_sw: memory-mapped push-key and switch input device.
//   clk, reset : clock, async active-high reset
//   key_in     : raw active-low keys (synchronized, inverted so pressed=1)
//   sw_in      : raw active-high switches (synchronized and debounced)
//   bus        : register bus slave (KDATA/KCTRL/SDATA/SCTRL)
//   intr       : level interrupt, (kready&kie)|(sready&sie), from flops only
// Each channel has a data register, a ready flag set on every new value and
// cleared by a DATA read, a sticky overrun flag, and an interrupt enable.
`timescale 1ns/1ps
module io_key_sw
    import io_pkg::*;
#(
    parameter int               DBITS           = 32,
    parameter int               KEY_BITS        = 4,
    parameter int               SW_BITS         = 10,
    parameter int               DEBOUNCE_CYCLES = 100000,
    parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(KDATA_ADDR),
    parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(KCTRL_ADDR),
    parameter logic [DBITS-1:0] ADDR_SDATA      = DBITS'(SDATA_ADDR),
    parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(SCTRL_ADDR)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic [SW_BITS-1:0]  sw_in,
    io_key_sw_if.slave          bus,
    output logic                intr
);
    // ---------------- key synchronizer (released = all ones) ----------------
    logic [KEY_BITS-1:0] key_meta_q, key_sync_q, key_pressed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
        end else begin
            key_meta_q <= key_in;
            key_sync_q <= key_meta_q;
        end
    end

    assign key_pressed = ~key_sync_q;

    // ---------------- switch synchronizer + debounce ----------------
    logic [SW_BITS-1:0] sw_cand;
    logic               sw_stable;

    io_debounce #(
        .WIDTH  (SW_BITS),
        .WINDOW (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk    (clk),
        .reset  (reset),
        .d_in   (sw_in),
        .cand   (sw_cand),
        .stable (sw_stable)
    );

    // ---------------- address decode ----------------
    logic hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;

    assign hit_kdata  = (bus.addr == ADDR_KDATA);
    assign hit_kctrl  = (bus.addr == ADDR_KCTRL);
    assign hit_sdata  = (bus.addr == ADDR_SDATA);
    assign hit_sctrl  = (bus.addr == ADDR_SCTRL);
    assign bus.rd_hit = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;

    // ---------------- channel state ----------------
    logic [KEY_BITS-1:0] kdata_d, kdata_q;
    logic [SW_BITS-1:0]  sdata_d, sdata_q;
    logic kready_d, kready_q, kovr_d, kovr_q, kie_d, kie_q;
    logic sready_d, sready_q, sovr_d, sovr_q, sie_d, sie_q;

    logic key_upd, key_rd, key_wr;
    logic sw_upd, sw_rd, sw_wr;

    assign key_upd = (key_pressed != kdata_q);
    assign key_rd  = bus.rd_en & hit_kdata;
    assign key_wr  = bus.wr_en & hit_kctrl;

    assign sw_upd  = sw_stable & (sw_cand != sdata_q);
    assign sw_rd   = bus.rd_en & hit_sdata;
    assign sw_wr   = bus.wr_en & hit_sctrl;

    // A new value wins over a coincident DATA read: ready stays set, and since
    // the read consumed the previous value no overrun is recorded.
    always_comb begin
        kdata_d  = kdata_q;
        kready_d = kready_q;
        kovr_d   = kovr_q;
        kie_d    = kie_q;
        if (key_upd) begin
            kdata_d  = key_pressed;
            kready_d = 1'b1;
        end else if (key_rd) begin
            kready_d = 1'b0;
        end
        if (key_upd && kready_q && !key_rd)
            kovr_d = 1'b1;
        else if (key_wr && !bus.wr_data[CTRL_OVR])
            kovr_d = 1'b0;
        if (key_wr)
            kie_d = bus.wr_data[CTRL_IE];
    end

    always_comb begin
        sdata_d  = sdata_q;
        sready_d = sready_q;
        sovr_d   = sovr_q;
        sie_d    = sie_q;
        if (sw_upd) begin
            sdata_d  = sw_cand;
            sready_d = 1'b1;
        end else if (sw_rd) begin
            sready_d = 1'b0;
        end
        if (sw_upd && sready_q && !sw_rd)
            sovr_d = 1'b1;
        else if (sw_wr && !bus.wr_data[CTRL_OVR])
            sovr_d = 1'b0;
        if (sw_wr)
            sie_d = bus.wr_data[CTRL_IE];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kdata_q  <= '0;
            kready_q <= 1'b0;
            kovr_q   <= 1'b0;
            kie_q    <= 1'b0;
            sdata_q  <= '0;
            sready_q <= 1'b0;
            sovr_q   <= 1'b0;
            sie_q    <= 1'b0;
        end else begin
            kdata_q  <= kdata_d;
            kready_q <= kready_d;
            kovr_q   <= kovr_d;
            kie_q    <= kie_d;
            sdata_q  <= sdata_d;
            sready_q <= sready_d;
            sovr_q   <= sovr_d;
            sie_q    <= sie_d;
        end
    end

    // ---------------- read mux (combinational from addr) ----------------
    always_comb begin
        bus.rd_data = '0;
        if (hit_kdata)
            bus.rd_data[KEY_BITS-1:0] = kdata_q;
        else if (hit_sdata)
            bus.rd_data[SW_BITS-1:0] = sdata_q;
        else if (hit_kctrl)
            bus.rd_data = DBITS'(ctrl_word(kready_q, kovr_q, kie_q));
        else if (hit_sctrl)
            bus.rd_data = DBITS'(ctrl_word(sready_q, sovr_q, sie_q));
    end

    assign intr = (kready_q & kie_q) | (sready_q & sie_q);

endmodule

// File: tb/tb_io_key_sw.sv
`timescale 1ns/1ps
module tb_io_key_sw;
    localparam int DEB = 4;
    localparam logic [31:0] A_KDATA = 32'hF000_0010;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SDATA = 32'hF000_0014;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_in;
    logic [9:0] sw_in;
    logic       intr;
    int         n_pass = 0;
    int         n_total = 0;

    io_key_sw_if #(.DBITS(32)) bus_if ();

    io_key_sw #(
        .DBITS(32), .KEY_BITS(4), .SW_BITS(10), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .key_in (key_in),
        .sw_in  (sw_in),
        .bus    (bus_if),
        .intr   (intr)
    );

    always #10 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Keys: the value pressed two edges ago becomes the reported key state.
    // Switches: a value is accepted once the last DEB synchronized samples
    // agree and it differs from what was last reported.
    logic [3:0] m_kh0, m_kh1, m_kdata;
    logic       m_kr, m_ko, m_kie;
    logic [9:0] m_sh0, m_sh1, m_sdata;
    logic [9:0] m_win [0:DEB-2];
    logic       m_sr, m_so, m_sie;

    always @(posedge clk or posedge reset) begin
        logic [3:0] kp;
        logic [9:0] sv;
        logic       kupd, supd, krd, srd, kwr, swr, settled;
        if (reset) begin
            m_kh0 <= 4'hF; m_kh1 <= 4'hF; m_kdata <= '0;
            m_kr <= 1'b0; m_ko <= 1'b0; m_kie <= 1'b0;
            m_sh0 <= '0; m_sh1 <= '0; m_sdata <= '0;
            for (int i = 0; i < DEB-1; i++) m_win[i] <= '0;
            m_sr <= 1'b0; m_so <= 1'b0; m_sie <= 1'b0;
        end else begin
            krd = bus_if.rd_en && (bus_if.addr == A_KDATA);
            kwr = bus_if.wr_en && (bus_if.addr == A_KCTRL);
            srd = bus_if.rd_en && (bus_if.addr == A_SDATA);
            swr = bus_if.wr_en && (bus_if.addr == A_SCTRL);

            kp   = ~m_kh1;
            kupd = (kp != m_kdata);
            m_kh0 <= key_in;
            m_kh1 <= m_kh0;
            if (kupd) begin m_kdata <= kp; m_kr <= 1'b1; end
            else if (krd) m_kr <= 1'b0;
            if (kupd && m_kr && !krd) m_ko <= 1'b1;
            else if (kwr && !bus_if.wr_data[2]) m_ko <= 1'b0;
            if (kwr) m_kie <= bus_if.wr_data[4];

            sv = m_sh1;
            settled = 1'b1;
            for (int i = 0; i < DEB-1; i++) if (m_win[i] != sv) settled = 1'b0;
            supd = settled && (sv != m_sdata);
            m_sh0 <= sw_in;
            m_sh1 <= m_sh0;
            m_win[0] <= sv;
            for (int i = 1; i < DEB-1; i++) m_win[i] <= m_win[i-1];
            if (supd) begin m_sdata <= sv; m_sr <= 1'b1; end
            else if (srd) m_sr <= 1'b0;
            if (supd && m_sr && !srd) m_so <= 1'b1;
            else if (swr && !bus_if.wr_data[2]) m_so <= 1'b0;
            if (swr) m_sie <= bus_if.wr_data[4];
        end
    end

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        case (a)
            A_KDATA: return {28'b0, m_kdata};
            A_KCTRL: return {27'b0, m_kie, 1'b0, m_ko, 1'b0, m_kr};
            A_SDATA: return {22'b0, m_sdata};
            A_SCTRL: return {27'b0, m_sie, 1'b0, m_so, 1'b0, m_sr};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_hit(input logic [31:0] a);
        return (a == A_KDATA) || (a == A_KCTRL) || (a == A_SDATA) || (a == A_SCTRL);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("rd_data", bus_if.rd_data, exp_rd(bus_if.addr));
        chk("rd_hit", {31'b0, bus_if.rd_hit}, {31'b0, exp_hit(bus_if.addr)});
        chk("intr", {31'b0, intr}, {31'b0, (m_kr & m_kie) | (m_sr & m_sie)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] e, input string nm);
        bus_if.addr = a; #1;
        chk(nm, bus_if.rd_data, e);
    endtask

    task automatic rd(input logic [31:0] a);
        bus_if.addr = a; bus_if.rd_en = 1'b1;
        cyc();
        bus_if.rd_en = 1'b0; bus_if.addr = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr = a; bus_if.wr_data = d; bus_if.wr_en = 1'b1;
        cyc();
        bus_if.wr_en = 1'b0; bus_if.addr = '0; bus_if.wr_data = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; key_in = 4'hF; sw_in = '0;
        bus_if.addr = '0; bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0; bus_if.wr_data = '0;
        repeat (3) cyc();
        peek(A_KDATA, 32'h0, "rst_kdata");
        peek(A_KCTRL, 32'h0, "rst_kctrl");
        peek(A_SDATA, 32'h0, "rst_sdata");
        peek(A_SCTRL, 32'h0, "rst_sctrl");
        chk("rst_intr", {31'b0, intr}, 32'h0);
        reset = 1'b0;
        repeat (4) cyc();

        // key press: visible three edges later, read clears ready
        key_in = 4'b1101;
        cyc(); cyc();
        peek(A_KDATA, 32'h0, "kdata_early");
        cyc();
        peek(A_KDATA, 32'h2, "kdata_press");
        peek(A_KCTRL, 32'h1, "kctrl_ready");
        rd(A_KDATA);
        peek(A_KCTRL, 32'h0, "kctrl_rd_clear");

        // two changes without a read -> overrun
        key_in = 4'hF; repeat (3) cyc();
        key_in = 4'b1110; repeat (3) cyc();
        peek(A_KCTRL, 32'h5, "kctrl_ovr");
        peek(A_KDATA, 32'h1, "kdata_second");
        wr(A_KCTRL, 32'h0);
        peek(A_KCTRL, 32'h1, "kovr_clear");
        key_in = 4'hF; repeat (3) cyc();
        peek(A_KCTRL, 32'h5, "kctrl_ovr2");
        wr(A_KCTRL, 32'h4);
        peek(A_KCTRL, 32'h5, "kovr_keep");
        wr(A_KCTRL, 32'h14);
        peek(A_KCTRL, 32'h15, "kie_set");
        chk("kintr_on", {31'b0, intr}, 32'h1);
        wr(A_KDATA, 32'hF);
        peek(A_KDATA, 32'h0, "kdata_wr_ignored");
        wr(A_KCTRL, 32'h0);
        peek(A_KCTRL, 32'h1, "kctrl_clr_all");
        chk("kintr_off", {31'b0, intr}, 32'h0);

        // key update coinciding with a KDATA read while ready is set
        key_in = 4'b0111;
        cyc(); cyc();
        rd(A_KDATA);
        peek(A_KCTRL, 32'h1, "kupd_wins_rd");
        peek(A_KDATA, 32'h8, "kdata_key3");
        rd(A_KDATA);
        peek(A_KCTRL, 32'h0, "kctrl_rd_clear2");
        peek(32'hF000_0018, 32'h0, "miss_data");
        chk("miss_hit", {31'b0, bus_if.rd_hit}, 32'h0);

        // switch glitch shorter than the window is ignored
        sw_in = 10'h3; repeat (3) cyc();
        sw_in = 10'h0; repeat (10) cyc();
        peek(A_SDATA, 32'h0, "sw_glitch");
        peek(A_SCTRL, 32'h0, "sw_glitch_rdy");

        // held switch accepted exactly 6 cycles after the change
        sw_in = 10'h155; repeat (5) cyc();
        peek(A_SDATA, 32'h0, "sw_early");
        cyc();
        peek(A_SDATA, 32'h155, "sw_settled");
        peek(A_SCTRL, 32'h1, "sw_ready");
        wr(A_SCTRL, 32'h10);
        chk("sintr_on", {31'b0, intr}, 32'h1);
        peek(A_SCTRL, 32'h11, "sctrl_ie");
        rd(A_SDATA);
        chk("sintr_off", {31'b0, intr}, 32'h0);
        sw_in = 10'h2AA; repeat (8) cyc();
        peek(A_SCTRL, 32'h11, "sctrl_rdy2");
        sw_in = 10'h0FF; repeat (8) cyc();
        peek(A_SCTRL, 32'h15, "sctrl_ovr");
        peek(A_SDATA, 32'h0FF, "sdata_ff");
        wr(A_SCTRL, 32'h0);
        peek(A_SCTRL, 32'h1, "sctrl_clr");

        // reset in the middle of a debounce window
        key_in = 4'hF; repeat (4) cyc();
        sw_in = 10'h001; repeat (2) cyc();
        reset = 1'b1; #1;
        chk("rst_mid_intr", {31'b0, intr}, 32'h0);
        peek(A_SDATA, 32'h0, "rst_mid_sdata");
        peek(A_SCTRL, 32'h0, "rst_mid_sctrl");
        peek(A_KCTRL, 32'h0, "rst_mid_kctrl");
        cyc(); cyc();
        reset = 1'b0;
        repeat (5) cyc();
        peek(A_SCTRL, 32'h0, "sw_post_rst_early");
        cyc();
        peek(A_SCTRL, 32'h1, "sw_post_rst_ready");
        peek(A_SDATA, 32'h1, "sw_post_rst_data");
        repeat (2) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
